// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr block: mode encodings,
// the default round-robin burst length and a clog2 helper for select-width checks.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int BURST_LEN_DEFAULT = 4;

    // Number of bits needed to encode 'value' distinct indices (clog2(1) = 0).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << bits) < 64'(value)) begin
                bits = bits + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning upward from
// last_grant+1 with wrap-around. No grant when disabled or when nothing requests.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    input  logic              enable,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_valid
);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("rr_arbiter: NUM_IN must be in 2..16");
    end
    if (clog2(NUM_IN) > SEL_W) begin : g_bad_sel_w
        $error("rr_arbiter: SEL_W too narrow for NUM_IN");
    end

    int idx;

    // Scan from the farthest candidate to the nearest so that the nearest
    // valid requester (highest priority) is the last one to overwrite grant.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (enable) begin
            for (int i = NUM_IN; i >= 1; i--) begin
                idx = (int'(last_grant) + i) % NUM_IN;
                if (req[idx]) begin
                    grant       = SEL_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input streaming mux with a one-entry registered output, fixed-select or
// round-robin mode. Define STREAM_MUX_BURST_EN to let a round-robin winner keep the grant for up to BURST_LEN beats.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 3,
    parameter int SEL_W     = 2,
    parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    if (clog2(NUM_IN) > SEL_W) begin : g_bad_sel_w
        $error("stream_mux_rr: 2**SEL_W must be >= NUM_IN");
    end
    if (BURST_LEN < 1) begin : g_bad_burst
        $error("stream_mux_rr: BURST_LEN must be >= 1");
    end

    // Handshake: a beat moves on a side only in a cycle where valid and ready
    // are both high at the rising edge. in_ready never depends on the same
    // channel's in_valid except through the grant, and it is one-hot or zero.
    logic             load;
    logic             accept;
    logic             fixed_ok;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] last_grant;
    logic [WIDTH-1:0] sel_data;

    assign load = !out_valid || out_ready;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req         (in_valid),
        .last_grant  (last_grant),
        .enable      (mode == MODE_RR),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // A select beyond the last channel must never grant.
    always_comb begin
        fixed_ok = 1'b0;
        if (int'(sel) < NUM_IN) begin
            fixed_ok = in_valid[sel];
        end
    end

`ifdef STREAM_MUX_BURST_EN
    localparam int CNT_W = clog2(BURST_LEN + 1);

    logic [CNT_W-1:0] burst_cnt;
    logic             burst_hold;

    assign burst_hold = (burst_cnt != '0) && (int'(burst_cnt) < BURST_LEN)
                        && in_valid[last_grant];

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (mode == MODE_FIXED) begin
            grant       = sel;
            grant_valid = fixed_ok;
        end else if (burst_hold) begin
            grant       = last_grant;
            grant_valid = 1'b1;
        end else begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end
    end

    // Counts consecutive round-robin beats of last_grant; zero means no burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (accept) begin
            if (mode != MODE_RR) begin
                burst_cnt <= '0;
            end else if (grant == last_grant && burst_cnt != '0
                         && int'(burst_cnt) < BURST_LEN) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                burst_cnt <= CNT_W'(1);
            end
        end else if (mode == MODE_RR && !in_valid[last_grant]) begin
            burst_cnt <= '0;
        end
    end
`else
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (mode == MODE_FIXED) begin
            grant       = sel;
            grant_valid = fixed_ok;
        end else begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end
    end
`endif

    always_comb begin
        in_ready = '0;
        if (load && grant_valid) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign accept   = |(in_ready & in_valid);
    assign sel_data = in_data[int'(grant)*WIDTH +: WIDTH];

    // Drain and reload may happen on the same edge, so full throughput needs no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Updated in both modes so round-robin stays fair after fixed-select traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= SEL_W'(NUM_IN - 1);
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: expected beats are queued when driven and
// compared as the consumer takes them. Also builds with STREAM_MUX_BURST_EN (BURST_LEN=2).
module tb_stream_mux_rr;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
`ifdef STREAM_MUX_BURST_EN
    localparam int BURST_LEN = 2;
    localparam int RR_SEQ[6]    = '{0, 0, 1, 1, 2, 2};
    localparam int SPARSE_N     = 3;
    localparam int SP_SEQ[3]    = '{2, 2, 0};
`else
    localparam int BURST_LEN = 4;
    localparam int RR_SEQ[6]    = '{0, 1, 2, 0, 1, 2};
    localparam int SPARSE_N     = 2;
    localparam int SP_SEQ[3]    = '{2, 0, 0};
`endif

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_src;

    int checks   = 0;
    int failures = 0;
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    stream_mux_rr #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .SEL_W     (SEL_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic rand_data();
        for (int c = 0; c < NUM_IN; c++) begin
            set_ch(c, WIDTH'($urandom_range(255)));
        end
    endtask

    task automatic expect_beat(input int ch);
        exp_q.push_back({SEL_W'(ch), in_data[ch*WIDTH +: WIDTH]});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: compare every beat the consumer takes against the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                logic [SEL_W+WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("beat_src", 32'(out_src), 32'(e[SEL_W+WIDTH-1:WIDTH]));
                check("beat_data", 32'(out_data), 32'(e[WIDTH-1:0]));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_src", 32'(out_src), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        rst = 1'b0;
        next_cycle();

        // fixed select of channel 2
        mode = 1'b0;
        sel  = 2'd2;
        set_ch(0, 8'h11);
        set_ch(1, 8'h22);
        set_ch(2, 8'h33);
        in_valid  = 3'b111;
        out_ready = 1'b1;
        expect_beat(2);
        @(negedge clk);
        check("fixed_in_ready", 32'(in_ready), 32'(3'b100));
        check("fixed_idle_before", 32'(out_valid), 32'(0));
        next_cycle();
        in_valid = '0;
        check("fixed_latency", 32'(out_valid), 32'(1));
        check("fixed_data", 32'(out_data), 32'(8'h33));
        next_cycle();
        check("fixed_drain", 32'(out_valid), 32'(0));

        // round-robin, all valid, full throughput
        mode     = 1'b1;
        in_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            expect_beat(RR_SEQ[k]);
            @(negedge clk);
            check("rr_in_ready", 32'(in_ready), 32'(1) << RR_SEQ[k]);
            if (k > 0) check("rr_no_bubble", 32'(out_valid), 32'(1));
            next_cycle();
        end

        // backpressure while holding 0xA5
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 3'b010;
        set_ch(1, 8'hA5);
        expect_beat(1);
        next_cycle();
        out_ready = 1'b0;
        set_ch(1, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_data", 32'(out_data), 32'(8'hA5));
            check("bp_hold_valid", 32'(out_valid), 32'(1));
            check("bp_in_ready", 32'(in_ready), 32'(0));
            next_cycle();
        end
        out_ready = 1'b1;
        expect_beat(1);
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'(3'b010));
        next_cycle();
        in_valid = '0;
        check("bp_reload_data", 32'(out_data), 32'(8'h5A));
        check("bp_reload_valid", 32'(out_valid), 32'(1));
        next_cycle();
        check("bp_drained", 32'(out_valid), 32'(0));

        // sparse round-robin: last grant is channel 1
        mode     = 1'b1;
        in_valid = 3'b010;
        rand_data();
        expect_beat(1);
        @(negedge clk);
        check("sparse_wrap_ready", 32'(in_ready), 32'(3'b010));
        next_cycle();
        in_valid = 3'b101;
        for (int k = 0; k < SPARSE_N; k++) begin
            rand_data();
            expect_beat(SP_SEQ[k]);
            @(negedge clk);
            check("sparse_in_ready", 32'(in_ready), 32'(1) << SP_SEQ[k]);
            next_cycle();
        end
        in_valid = '0;
        next_cycle();
        check("sparse_drained", 32'(out_valid), 32'(0));

        // illegal select never grants
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("illegal_in_ready", 32'(in_ready), 32'(0));
            check("illegal_out_valid", 32'(out_valid), 32'(0));
            next_cycle();
        end

        // asynchronous reset with a beat held in the output register
        sel       = 2'd0;
        in_valid  = 3'b001;
        out_ready = 1'b0;
        set_ch(0, 8'hC3);
        next_cycle();
        in_valid = '0;
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        check("pre_rst_data", 32'(out_data), 32'(8'hC3));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'(0));
        check("async_rst_data", 32'(out_data), 32'(0));
        check("async_rst_src", 32'(out_src), 32'(0));
        next_cycle();
        rst       = 1'b0;
        mode      = 1'b1;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        rand_data();
        expect_beat(0);
        @(negedge clk);
        check("post_rst_rr_first", 32'(in_ready), 32'(3'b001));
        next_cycle();
        in_valid = '0;
        next_cycle();
        check("final_drained", 32'(out_valid), 32'(0));

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-input, W-bit streaming multiplexer with a registered output. It is the successor to the fixed 8-bit cascaded select muxes. It adds valid/ready handshakes, a one-entry output register, and a runtime mode: either a fixed select or round-robin arbitration across valid inputs. It sits between multiple producers and a single consumer on the datapath.

Parameters:
WIDTH, 8, data bits per channel
NUM_IN, 3, number of input channels (2..16)
SEL_W, 2, select/source width; must satisfy 2**SEL_W >= NUM_IN
BURST_LEN, 4, maximum consecutive round-robin grants to one channel (used only with STREAM_MUX_BURST_EN)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-channel data valid
in_ready  output  NUM_IN  per-channel accept; one-hot or zero
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
out_data  output  WIDTH  registered selected data
out_valid  output  1  output register holds a beat
out_ready  input  1  consumer accepts beat
out_src  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - last_grant=NUM_IN-1, so channel 0 has first round-robin priority.
  - Burst counter=0.
- load = !out_valid | out_ready. This is a combinational decision.
- Grant selection (combinational):
  - mode=0: grant channel sel if sel<NUM_IN and in_valid[sel]=1. Otherwise no grant. sel>=NUM_IN never grants.
  - mode=1: grant the first valid channel found scanning (last_grant+1) mod NUM_IN upward, with wrap. No valid inputs means no grant.
- in_ready[g] = load & grant_valid for the granted channel g. All other bits of in_ready are 0.
- Accepting a beat (in_ready[g] & in_valid[g]):
  - Next edge: out_data=in_data[g], out_src=g, out_valid=1.
  - Latency is one cycle, input to out_valid.
- Drain without a new beat (out_valid & out_ready, no accept): next edge out_valid=0. out_data and out_src hold their values.
- Simultaneous drain and accept: the register reloads in the same edge. This sustains one beat per cycle with no bubble.
- Backpressure (out_valid & !out_ready): out_data, out_src and out_valid hold. in_ready is all 0.
- last_grant updates only on an accepted beat, in either mode. This keeps round-robin fair after a fixed-mode period.
- Changing mode or sel mid-stream takes effect on the next grant evaluation. An already-registered beat is never altered.
- rst asserted mid-transfer: outputs clear immediately and asynchronously, and the in-flight beat is dropped.
- Inputs are sampled only under handshake. in_data of unselected channels is don't-care.

Optional Feature:
STREAM_MUX_BURST_EN
- Defined, mode=1: a channel that just won keeps the grant while it stays valid, for up to BURST_LEN consecutive accepted beats.
- The counter resets when the grant changes or the channel deasserts valid. On reaching BURST_LEN, rotation proceeds normally.
- Undefined: strict one-beat round-robin. BURST_LEN is unused and no counter logic exists.
- mode=0 is unaffected in both cases.

Decomposition:
- Package mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - A clog2 helper function for SEL_W checking.
  - The BURST_LEN default constant.
- One sub-module, rr_arbiter (NUM_IN, SEL_W). Inputs: req vector, last_grant, enable. Outputs: grant index and grant_valid.
- stream_mux_rr owns the output register, the handshake logic, last_grant, and the optional burst counter.

Test Plan:
1. Reset: assert rst mid-beat with out_valid=1 -> out_valid=0, out_data=0 and out_src=0 immediately, with no clock edge. After release, the first RR grant goes to channel 0.
2. Fixed mode: mode=0, sel=2, all valid, data {0x33,0x22,0x11} for ch2..ch0, out_ready=1 -> out_data=0x33 and out_src=2 one cycle later. in_ready=3'b100 only.
3. Round-robin: mode=1, all valid, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,0,1,2 with no bubbles. With STREAM_MUX_BURST_EN and BURST_LEN=2, the sequence is 0,0,1,1,2,2.
4. Backpressure: out_ready=0 for 3 cycles while holding 0xA5 -> out_data stays 0xA5 and in_ready=0. Raising out_ready gives a drain and a reload in the same cycle.
5. Sparse requests: mode=1, only ch1 valid, last_grant=1 -> scan wraps and grants ch1 again. Then ch0 and ch2 become valid -> order is ch2, then ch0.
6. Illegal select: mode=0, sel=3 with NUM_IN=3 -> in_ready=0 and out_valid stays 0 indefinitely.
